// File: rtl/fifomem_mc.sv
// Multi-channel FIFO: NUM_CH independent queues carved out of one shared array, one write and one read port.
// Define FIFOMEM_MC_ERR_FLAGS_EN to build the sticky overflow/underflow registers; otherwise both outputs read 0.
module fifomem_mc #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int NUM_CH       = 4,
  parameter int AFULL_THRESH = 12,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W       = ADDR_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [CH_W-1:0]           wch,
  input  logic                      wclken,
  input  logic [CH_W-1:0]           rch,
  input  logic                      rclken,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      rvalid,
  output logic [NUM_CH-1:0]         wfull,
  output logic [NUM_CH-1:0]         rempty,
  output logic [NUM_CH-1:0]         afull,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         overflow,
  output logic [NUM_CH-1:0]         underflow
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam int                MEM_AW   = CH_W + ADDR_WIDTH;
  localparam logic [CH_W:0]     NUM_CH_C = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_C  = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] r_mem  [NUM_CH*DEPTH];
  logic [CNT_W-1:0]      r_wptr [NUM_CH];
  logic [CNT_W-1:0]      r_rptr [NUM_CH];
  logic [CNT_W-1:0]      w_cnt  [NUM_CH];
  logic [DATA_WIDTH-1:0] r_rdata_p1;
  logic                  r_rvld_p1;

  logic              w_wch_ok, w_rch_ok, w_wr_acc, w_rd_acc;
  logic [MEM_AW-1:0] w_waddr, w_raddr;

  // Channel-major addressing: {ch, slot} equals ch*DEPTH + slot.
  assign w_wch_ok = ({1'b0, wch} < NUM_CH_C);
  assign w_rch_ok = ({1'b0, rch} < NUM_CH_C);
  assign w_wr_acc = wclken && w_wch_ok && !wfull[wch];
  assign w_rd_acc = rclken && w_rch_ok && !rempty[rch];
  assign w_waddr  = {wch, r_wptr[wch][ADDR_WIDTH-1:0]};
  assign w_raddr  = {rch, r_rptr[rch][ADDR_WIDTH-1:0]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_flag
    assign w_cnt[c]                  = r_wptr[c] - r_rptr[c];
    assign rempty[c]                 = (w_cnt[c] == '0);
    assign wfull[c]                  = (w_cnt[c] == DEPTH_C);
    assign afull[c]                  = (w_cnt[c] >= AFULL_C);
    assign count[c*CNT_W +: CNT_W]   = w_cnt[c];
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) r_mem[w_waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end
    end else begin
      if (w_wr_acc) r_wptr[wch] <= r_wptr[wch] + CNT_W'(1);
      if (w_rd_acc) r_rptr[rch] <= r_rptr[rch] + CNT_W'(1);
    end
  end

  // Read stage: one-cycle latency, rdata holds on rejected or idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata_p1 <= '0;
      r_rvld_p1  <= 1'b0;
    end else begin
      r_rvld_p1 <= w_rd_acc;
      if (w_rd_acc) r_rdata_p1 <= r_mem[w_raddr];
    end
  end

  assign rdata  = r_rdata_p1;
  assign rvalid = r_rvld_p1;

`ifdef FIFOMEM_MC_ERR_FLAGS_EN
  logic [NUM_CH-1:0] r_ovf, r_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      if (wclken && w_wch_ok && wfull[wch])  r_ovf[wch] <= 1'b1;
      if (rclken && w_rch_ok && rempty[rch]) r_udf[rch] <= 1'b1;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;
`else
  assign overflow  = '0;
  assign underflow = '0;
`endif

endmodule

// File: tb/tb_fifomem_mc.sv
// Directed bench for fifomem_mc: fill/drain, wrap, simultaneous access, channel isolation, mid-run reset.
module tb_fifomem_mc;
  localparam int CW = 5;
`ifdef FIFOMEM_MC_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wclken, rclken;
  logic [7:0]  wdata;
  logic [1:0]  wch, rch;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [3:0]  wfull, rempty, afull, overflow, underflow;
  logic [19:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  fifomem_mc #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CH(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wch(wch), .wclken(wclken),
    .rch(rch), .rclken(rclken), .rdata(rdata), .rvalid(rvalid),
    .wfull(wfull), .rempty(rempty), .afull(afull), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                     input logic re, input logic [1:0] rc);
    wclken = we; wch = wc; wdata = wd; rclken = re; rch = rc;
    @(posedge clk); #1;
    wclken = 1'b0; rclken = 1'b0;
  endtask

  function automatic logic [4:0] cnt(input int c);
    return count[c*CW +: CW];
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rempty"}, rempty, 4'hF);
    chk({tag, "_wfull"}, wfull, 4'h0);
    chk({tag, "_afull"}, afull, 4'h0);
    chk({tag, "_count"}, count, 20'h0);
    chk({tag, "_rdata"}, rdata, 8'h00);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_ovf"}, overflow, 4'h0);
    chk({tag, "_udf"}, underflow, 4'h0);
  endtask

  initial begin
    rst = 1'b1; wclken = 1'b0; rclken = 1'b0; wdata = '0; wch = '0; rch = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk_reset_state("rst");

    // Fill channel 2 to full
    for (int i = 0; i < 16; i++) begin
      cyc(1, 2'd2, 8'(i), 0, 0);
      if (i == 10) chk("afull_at11", afull, 4'h0);
      if (i == 11) chk("afull_at12", afull, 4'b0100);
    end
    chk("full_wfull", wfull, 4'b0100);
    chk("full_count2", cnt(2), 5'd16);
    chk("full_rempty", rempty, 4'b1011);
    cyc(1, 2'd2, 8'hAA, 0, 0);
    chk("ovf_count2", cnt(2), 5'd16);
    chk("ovf_flag", overflow, {4{ERR}} & 4'b0100);
    chk("ovf_udf", underflow, 4'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 2'd2);
      chk("drain2_data", rdata, 8'(i));
      chk("drain2_vld", rvalid, 1'b1);
      if (i == 3) chk("drain2_afull12", afull, 4'b0100);
      if (i == 4) chk("drain2_afull11", afull, 4'h0);
    end
    chk("drain2_rempty", rempty, 4'hF);
    chk("drain2_count", count, 20'h0);
    cyc(0, 0, 0, 0, 0);
    chk("idle_rvalid", rvalid, 1'b0);
    chk("idle_rdata_hold", rdata, 8'h0F);

    // Streaming with 1-cycle lag across pointer wrap on channel 0
    for (int k = 0; k <= 40; k++) begin
      cyc(k < 40, 2'd0, 8'(8'h40 + k), k >= 1, 2'd0);
      if (k >= 1) begin
        chk("wrap_data", rdata, 8'(8'h40 + k - 1));
        chk("wrap_vld", rvalid, 1'b1);
      end
      chk("wrap_count0", cnt(0), (k < 40) ? 5'd1 : 5'd0);
    end

    // Simultaneous write+read on channel 3 at count 5
    for (int i = 0; i < 5; i++) cyc(1, 2'd3, 8'(8'h50 + i), 0, 0);
    chk("sim5_pre", cnt(3), 5'd5);
    cyc(1, 2'd3, 8'h55, 1, 2'd3);
    chk("sim5_data", rdata, 8'h50);
    chk("sim5_vld", rvalid, 1'b1);
    chk("sim5_count", cnt(3), 5'd5);
    for (int i = 0; i < 11; i++) cyc(1, 2'd3, 8'(8'h56 + i), 0, 0);
    chk("simf_pre", wfull, 4'b1000);
    cyc(1, 2'd3, 8'hEE, 1, 2'd3);
    chk("simf_data", rdata, 8'h51);
    chk("simf_count", cnt(3), 5'd15);
    chk("simf_ovf", overflow, {4{ERR}} & 4'b1100);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 1, 2'd3);
      chk("simf_drain", rdata, 8'(8'h52 + i));
    end
    chk("sime_pre", rempty, 4'hF);
    cyc(1, 2'd3, 8'h77, 1, 2'd3);
    chk("sime_vld", rvalid, 1'b0);
    chk("sime_hold", rdata, 8'h60);
    chk("sime_udf", underflow, {4{ERR}} & 4'b1000);
    chk("sime_count", cnt(3), 5'd1);
    cyc(0, 0, 0, 1, 2'd3);
    chk("sime_rd", rdata, 8'h77);

    // Channel isolation: writes to 0/1/3, reads from 1 only
    cyc(1, 2'd1, 8'hB0, 0, 0);
    cyc(1, 2'd0, 8'hA0, 0, 0);
    cyc(1, 2'd1, 8'hB1, 1, 2'd1);
    chk("iso_rd0", rdata, 8'hB0);
    cyc(1, 2'd3, 8'hC0, 1, 2'd1);
    chk("iso_rd1", rdata, 8'hB1);
    chk("iso_cnt_a", count, {5'd1, 5'd0, 5'd0, 5'd1});
    cyc(1, 2'd0, 8'hA1, 0, 0);
    chk("iso_cnt_b", count, {5'd1, 5'd0, 5'd0, 5'd2});

    // Channel 1 to count 7 with overflow set, then reset mid-operation
    for (int i = 0; i < 17; i++) cyc(1, 2'd1, 8'(8'h10 + i), 0, 0);
    chk("pre_rst_ovf", overflow, {4{ERR}} & 4'b1110);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 2'd1);
      chk("pre_rst_rd", rdata, 8'(8'h10 + i));
    end
    chk("pre_rst_cnt1", cnt(1), 5'd7);
    rst = 1'b1;
    cyc(1, 2'd1, 8'hDD, 1, 2'd1);
    rst = 1'b0;
    chk_reset_state("midrst");
    cyc(1, 2'd1, 8'h5A, 0, 0);
    chk("post_cnt1", cnt(1), 5'd1);
    cyc(0, 0, 0, 1, 2'd1);
    chk("post_rd", rdata, 8'h5A);
    chk("post_vld", rvalid, 1'b1);
    chk("post_empty", rempty, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
